// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with boundary-synchronised ratio updates.
// Define CLK_DIV_ODD50_EN to add a negedge flop that gives exact 50 % duty for odd ratios.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_clk_div,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_req_c;
  logic [WIDTH-1:0] half_c;
  logic [WIDTH-1:0] cnt_inc_c;
  logic             wrap_c;

  assign div_req_c = (i_div < DIV_MIN) ? DIV_MIN : i_div;
  assign half_c    = div_act_q >> 1;
  assign cnt_inc_c = cnt_q + WIDTH'(1);
  assign wrap_c    = (cnt_q == (div_act_q - WIDTH'(1)));

  // Next-state: loads always land in pending; the active ratio only changes on a wrap.
  always_comb begin
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;

    if (i_div_load) begin
      div_pend_d = div_req_c;
      pend_vld_d = 1'b1;
    end

    if (i_clk_en) begin
      if (wrap_c) begin
        cnt_d     = '0;
        clk_div_d = 1'b1;
        tick_d    = 1'b1;
        if (i_div_load) begin
          div_act_d  = div_req_c;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          div_act_d  = div_pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d     = cnt_inc_c;
        clk_div_d = (cnt_inc_c < half_c);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_vld_q <= 1'b0;
      cnt_q      <= CNT_RST;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic clk_div_n_q, clk_div_n_d;

  // Half-cycle extension of the high phase, only for odd ratios.
  assign clk_div_n_d = i_clk_en ? (clk_div_q & div_act_q[0]) : clk_div_n_q;

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_div_n_q <= 1'b0;
    end else begin
      clk_div_n_q <= clk_div_n_d;
    end
  end

  assign o_clk_div = clk_div_q | clk_div_n_q;
`else
  assign o_clk_div = clk_div_q;
`endif

  assign o_tick    = tick_q;
  assign o_pending = pend_vld_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (default ratio 2, 8-bit ratio field).
module tb_clk_div_prog;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             i_clk_en;
  logic [WIDTH-1:0] i_div;
  logic             i_div_load;
  logic             o_clk_div;
  logic             o_tick;
  logic             o_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_clk_en   (i_clk_en),
    .i_div      (i_div),
    .i_div_load (i_div_load),
    .o_clk_div  (o_clk_div),
    .o_tick     (o_tick),
    .o_pending  (o_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_clk_en = 1'b1; i_div = '0; i_div_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_clk_div !== 1'b0) begin bad++; $display("FAIL reset_clk got=%0b want=0", o_clk_div); end
    total++; if (o_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b want=0", o_tick); end
    total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b want=0", o_pending); end
    resetn = 1'b1;
  endtask

  task automatic test_default();
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (o_clk_div !== ((i % 2) == 0)) begin bad++; $display("FAIL default_clk[%0d] got=%0b want=%0b", i, o_clk_div, (i % 2) == 0); end
      total++; if (o_tick !== ((i % 2) == 0)) begin bad++; $display("FAIL default_tick[%0d] got=%0b want=%0b", i, o_tick, (i % 2) == 0); end
    end
    total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL default_pending got=%0b want=0", o_pending); end
  endtask

  task automatic test_load4();
    i_div = 8'd4; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_pending !== 1'b1) begin bad++; $display("FAIL load4_pending_rise got=%0b want=1", o_pending); end
    total++; if (o_clk_div !== 1'b0) begin bad++; $display("FAIL load4_old_period got=%0b want=0", o_clk_div); end
    step();
    total++; if (o_clk_div !== 1'b1 || o_tick !== 1'b1) begin bad++; $display("FAIL load4_wrap clk=%0b tick=%0b want 1/1", o_clk_div, o_tick); end
    total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL load4_pending_fall got=%0b want=0", o_pending); end
    for (int j = 1; j < 8; j++) begin
      step();
      total++; if (o_clk_div !== ((j % 4) < 2)) begin bad++; $display("FAIL load4_clk[%0d] got=%0b want=%0b", j, o_clk_div, (j % 4) < 2); end
      total++; if (o_tick !== ((j % 4) == 0)) begin bad++; $display("FAIL load4_tick[%0d] got=%0b want=%0b", j, o_tick, (j % 4) == 0); end
    end
  endtask

  // Load issued in the wrap cycle: applied at once, pending never seen.
  task automatic test_wrap_load();
    i_div = 8'd5; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_clk_div !== 1'b1 || o_tick !== 1'b1) begin bad++; $display("FAIL wrapload_edge clk=%0b tick=%0b want 1/1", o_clk_div, o_tick); end
    total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL wrapload_pending got=%0b want=0", o_pending); end
  endtask

  task automatic test_odd();
    int hi;
    int tk;
    int exp_hi;
`ifdef CLK_DIV_ODD50_EN
    exp_hi = 5;
`else
    exp_hi = 4;
`endif
    hi = int'(o_clk_div);
    tk = int'(o_tick);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      hi += int'(o_clk_div);
      if (k < 4) begin
        step();
        hi += int'(o_clk_div);
        tk += int'(o_tick);
      end
    end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL odd5_high_halves got=%0d want=%0d", hi, exp_hi); end
    total++; if (tk !== 1) begin bad++; $display("FAIL odd5_ticks got=%0d want=1", tk); end
    step();
    total++; if (o_clk_div !== 1'b1 || o_tick !== 1'b1) begin bad++; $display("FAIL odd5_period_end clk=%0b tick=%0b want 1/1", o_clk_div, o_tick); end
  endtask

  task automatic test_back_to_back();
    i_div = 8'd4; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    repeat (3) step();
    step();
    total++; if (o_tick !== 1'b1 || o_pending !== 1'b0) begin bad++; $display("FAIL b2b_to4 tick=%0b pend=%0b want 1/0", o_tick, o_pending); end
    step();
    i_div = 8'd6; i_div_load = 1'b1;
    step();
    total++; if (o_clk_div !== 1'b0 || o_pending !== 1'b1) begin bad++; $display("FAIL b2b_load6 clk=%0b pend=%0b want 0/1", o_clk_div, o_pending); end
    i_div = 8'd3;
    step();
    i_div_load = 1'b0;
    total++; if (o_clk_div !== 1'b0 || o_tick !== 1'b0) begin bad++; $display("FAIL b2b_intact clk=%0b tick=%0b want 0/0", o_clk_div, o_tick); end
    step();
    total++; if (o_clk_div !== 1'b1 || o_tick !== 1'b1 || o_pending !== 1'b0) begin bad++; $display("FAIL b2b_wrap4 clk=%0b tick=%0b pend=%0b want 1/1/0", o_clk_div, o_tick, o_pending); end
    for (int j = 1; j < 4; j++) begin
      step();
      total++; if (o_clk_div !== (j == 3) || o_tick !== (j == 3)) begin bad++; $display("FAIL b2b_n3[%0d] clk=%0b tick=%0b want %0b", j, o_clk_div, o_tick, j == 3); end
    end
  endtask

  task automatic test_clamp();
    i_div = 8'd0; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_pending !== 1'b1) begin bad++; $display("FAIL clamp0_pending got=%0b want=1", o_pending); end
    repeat (2) step();
    total++; if (o_tick !== 1'b1) begin bad++; $display("FAIL clamp0_wrap got=%0b want=1", o_tick); end
    for (int j = 1; j < 5; j++) begin
      step();
      total++; if (o_clk_div !== ((j % 2) == 0)) begin bad++; $display("FAIL clamp0_clk[%0d] got=%0b want=%0b", j, o_clk_div, (j % 2) == 0); end
    end
    i_div = 8'd1; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_pending !== 1'b1) begin bad++; $display("FAIL clamp1_pending got=%0b want=1", o_pending); end
    for (int j = 0; j < 4; j++) begin
      step();
      total++; if (o_clk_div !== ((j % 2) == 0) || o_tick !== ((j % 2) == 0)) begin bad++; $display("FAIL clamp1[%0d] clk=%0b tick=%0b want %0b", j, o_clk_div, o_tick, (j % 2) == 0); end
    end
  endtask

  task automatic test_freeze();
    i_div = 8'd4; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_tick !== 1'b1 || o_pending !== 1'b0) begin bad++; $display("FAIL freeze_setup tick=%0b pend=%0b want 1/0", o_tick, o_pending); end
    i_clk_en = 1'b0;
    i_div = 8'd6;
    for (int k = 0; k < 7; k++) begin
      i_div_load = (k == 2);
      step();
      total++; if (o_clk_div !== 1'b1 || o_tick !== 1'b0) begin bad++; $display("FAIL freeze_hold[%0d] clk=%0b tick=%0b want 1/0", k, o_clk_div, o_tick); end
      total++; if (o_pending !== (k >= 2)) begin bad++; $display("FAIL freeze_pending[%0d] got=%0b want=%0b", k, o_pending, k >= 2); end
    end
    i_div_load = 1'b0;
    i_clk_en = 1'b1;
    for (int j = 1; j < 4; j++) begin
      step();
      total++; if (o_clk_div !== (j < 2) || o_tick !== 1'b0) begin bad++; $display("FAIL freeze_resume[%0d] clk=%0b tick=%0b want %0b/0", j, o_clk_div, o_tick, j < 2); end
    end
    step();
    total++; if (o_tick !== 1'b1 || o_pending !== 1'b0) begin bad++; $display("FAIL freeze_wrap tick=%0b pend=%0b want 1/0", o_tick, o_pending); end
    for (int j = 1; j < 7; j++) begin
      step();
      total++; if (o_clk_div !== ((j % 6) < 3) || o_tick !== (j == 6)) begin bad++; $display("FAIL n6[%0d] clk=%0b tick=%0b want %0b/%0b", j, o_clk_div, o_tick, (j % 6) < 3, j == 6); end
    end
  endtask

  task automatic test_reset_mid();
    i_div = 8'd9; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    total++; if (o_clk_div !== 1'b1 || o_pending !== 1'b1) begin bad++; $display("FAIL rstmid_pre clk=%0b pend=%0b want 1/1", o_clk_div, o_pending); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (o_clk_div !== 1'b0 || o_tick !== 1'b0 || o_pending !== 1'b0) begin bad++; $display("FAIL rstmid_async clk=%0b tick=%0b pend=%0b want 0/0/0", o_clk_div, o_tick, o_pending); end
    repeat (2) step();
    resetn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      total++; if (o_clk_div !== ((j % 2) == 0) || o_tick !== ((j % 2) == 0) || o_pending !== 1'b0) begin bad++; $display("FAIL rstmid_after[%0d] clk=%0b tick=%0b pend=%0b want %0b", j, o_clk_div, o_tick, o_pending, (j % 2) == 0); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load4();
    test_wrap_load();
    test_odd();
    test_back_to_back();
    test_clamp();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
